// File: rtl/stream_arb_mux_pkg.sv
// stream_arb_mux_pkg
//   Shared constants and helpers for the arbitrated stream mux and for
//   other multi-master blocks that reuse rr_arbiter.
//   ARB_FIXED / ARB_RR : arbitration mode encodings
//   num_ch(aw)         : channel count for an index width of aw bits
package stream_arb_mux_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  function automatic int num_ch(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/stream_arb_mux_rr_arbiter.sv
// rr_arbiter
//   Combinational N-way arbiter with a selectable search origin.
//   req     in  N   request vector
//   ptr     in  AW  search start when mode=1 (round-robin)
//   mode    in  1   0 = fixed priority from index 0, 1 = search from ptr
//   grant   out AW  index of the winning request (0 when no request)
//   any_req out 1   at least one request present
module rr_arbiter
  import stream_arb_mux_pkg::*;
#(
  parameter int AW = 2
) (
  input  logic [num_ch(AW)-1:0] req,
  input  logic [AW-1:0]         ptr,
  input  logic                  mode,
  output logic [AW-1:0]         grant,
  output logic                  any_req
);

  localparam int N = num_ch(AW);

  logic [AW-1:0] base;
  logic [AW-1:0] idx;

  assign base    = mode ? ptr : '0;
  assign any_req = |req;

  // Walk the rotated order from the far end back to the origin so the
  // request closest to the origin is the last (winning) assignment.
  // The AW-bit add wraps modulo N for free.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = base + AW'(k);
      if (req[idx]) grant = idx;
    end
  end

endmodule

// File: rtl/stream_arb_mux.sv
// stream_arb_mux
//   Merges N = 2**ADDRESS_WIDTH valid/ready streams onto one registered
//   output stream; the winning channel index travels with the data.
//   clk          in  1             rising-edge clock
//   rst          in  1             synchronous active-high reset
//   in_data      in  DATA_WIDTH*N  packed words, channel i at slice i
//   in_valid     in  N             per-channel valid
//   in_ready     out N             per-channel ready (combinational)
//   out_data     out DATA_WIDTH    registered selected word
//   out_address  out ADDRESS_WIDTH channel that supplied out_data
//   out_valid    out 1             output word valid
//   out_ready    in  1             sink ready
module stream_arb_mux
  import stream_arb_mux_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 2,
  parameter int RR_MODE       = ARB_RR
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [DATA_WIDTH*num_ch(ADDRESS_WIDTH)-1:0] in_data,
  input  logic [num_ch(ADDRESS_WIDTH)-1:0]         in_valid,
  output logic [num_ch(ADDRESS_WIDTH)-1:0]         in_ready,
  output logic [DATA_WIDTH-1:0]                    out_data,
  output logic [ADDRESS_WIDTH-1:0]                 out_address,
  output logic                                     out_valid,
  input  logic                                     out_ready
);

  localparam int N = num_ch(ADDRESS_WIDTH);

  logic [N-1:0][DATA_WIDTH-1:0] words;
  logic [ADDRESS_WIDTH-1:0]     ptr;
  logic [ADDRESS_WIDTH-1:0]     grant;
  logic                         any_req;
  logic                         load;

  assign words = in_data;

  rr_arbiter #(.AW(ADDRESS_WIDTH)) u_arb (
    .req     (in_valid),
    .ptr     (ptr),
    .mode    (RR_MODE == ARB_RR),
    .grant   (grant),
    .any_req (any_req)
  );

  // Load whenever the register is empty or draining this edge; reset
  // suppresses every input handshake in its cycle.
  assign load = any_req && (!out_valid || out_ready) && !rst;

  for (genvar i = 0; i < N; i++) begin : g_rdy
    assign in_ready[i] = load && (grant == ADDRESS_WIDTH'(i));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_address <= '0;
      ptr         <= '0;
    end else if (load) begin
      out_data    <= words[grant];
      out_address <= grant;
      out_valid   <= 1'b1;
      if (RR_MODE == ARB_RR) ptr <= grant + ADDRESS_WIDTH'(1);
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_arb_mux.sv
// tb_stream_arb_mux
//   Drives a round-robin and a fixed-priority instance with identical
//   stimulus. A driver predicts handshakes from a queue-level model and
//   pushes expected words; a monitor pops and compares presented words.
module tb_stream_arb_mux;

  localparam int DW = 8;
  localparam int AW = 2;
  localparam int N  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW*N-1:0] in_data = '0;
  logic [N-1:0]  in_valid = '0;
  logic          out_ready = 1'b0;

  logic [N-1:0]  in_rdy [2];
  logic [DW-1:0] od     [2];
  logic [AW-1:0] oa     [2];
  logic          ov     [2];

  always #5 clk = ~clk;

  stream_arb_mux #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .RR_MODE(1)) u_rr (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_rdy[0]), .out_data(od[0]), .out_address(oa[0]),
    .out_valid(ov[0]), .out_ready(out_ready)
  );

  stream_arb_mux #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .RR_MODE(0)) u_fx (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_rdy[1]), .out_data(od[1]), .out_address(oa[1]),
    .out_valid(ov[1]), .out_ready(out_ready)
  );

  int tests = 0;
  int fails = 0;

  // Model state: next channel to favour (round-robin only), whether each
  // output register should hold a word, and the words still owed.
  int   m_next = 0;
  bit   m_full [2] = '{0, 0};
  bit   prev_rst = 1'b1;
  logic [AW+DW-1:0] q0[$];
  logic [AW+DW-1:0] q1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Winner by rule: round-robin favours m_next then walks upward with
  // wrap; fixed priority always favours channel 0.
  function automatic int winner(input int k, input logic [N-1:0] v);
    int start;
    start = (k == 0) ? m_next : 0;
    for (int j = 0; j < N; j++)
      if (v[(start + j) % N]) return (start + j) % N;
    return 0;
  endfunction

  task automatic drive(input logic [N-1:0] v, input logic ordy, input logic r, input bit pat);
    bit ld;
    int g;
    @(negedge clk);
    for (int i = 0; i < N; i++)
      in_data[i*DW +: DW] = pat ? 8'(8'hA0 + i) : 8'($urandom);
    in_valid  = v;
    out_ready = ordy;
    rst       = r;
    #2;
    for (int k = 0; k < 2; k++) begin
      chk(k == 0 ? "rr_out_valid" : "fx_out_valid", 32'(ov[k]), 32'(m_full[k]));
      if (prev_rst) begin
        chk(k == 0 ? "rr_rst_data" : "fx_rst_data", 32'(od[k]), 0);
        chk(k == 0 ? "rr_rst_addr" : "fx_rst_addr", 32'(oa[k]), 0);
      end
      ld = !r && (v != 0) && (!m_full[k] || ordy);
      g  = winner(k, v);
      chk(k == 0 ? "rr_in_ready" : "fx_in_ready", 32'(in_rdy[k]), ld ? (32'd1 << g) : 32'd0);
      if (r) begin
        if (k == 0) begin q0.delete(); m_next = 0; end
        else q1.delete();
        m_full[k] = 1'b0;
      end else if (ld) begin
        if (k == 0) begin
          q0.push_back({AW'(g), in_data[g*DW +: DW]});
          m_next = (g + 1) % N;
        end else begin
          q1.push_back({AW'(g), in_data[g*DW +: DW]});
        end
        m_full[k] = 1'b1;
      end else if (m_full[k] && ordy) begin
        m_full[k] = 1'b0;
      end
    end
    prev_rst = r;
  endtask

  // Monitor: every presented word must be the oldest owed word; it is
  // retired when the sink accepts it.
  initial begin
    logic [AW+DW-1:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (!rst) begin
        for (int k = 0; k < 2; k++) begin
          if (ov[k]) begin
            if ((k == 0 ? q0.size() : q1.size()) == 0) begin
              chk(k == 0 ? "rr_unexpected_word" : "fx_unexpected_word", 32'(ov[k]), 0);
            end else begin
              e = (k == 0) ? q0[0] : q1[0];
              chk(k == 0 ? "rr_out_data" : "fx_out_data", 32'(od[k]), 32'(e[DW-1:0]));
              chk(k == 0 ? "rr_out_addr" : "fx_out_addr", 32'(oa[k]), 32'(e[AW+DW-1:DW]));
              if (out_ready) begin
                if (k == 0) void'(q0.pop_front());
                else void'(q1.pop_front());
              end
            end
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, fails=%0d", fails);
    $fatal(1, "watchdog");
  end

  initial begin
    // reset held two cycles with every channel requesting
    drive(4'hF, 1'b1, 1'b1, 1'b1);
    drive(4'hF, 1'b1, 1'b1, 1'b1);
    // round-robin fairness / fixed-priority on full request
    repeat (5) drive(4'hF, 1'b1, 1'b0, 1'b1);
    // channel 3 starved behind channel 1 in fixed mode
    repeat (4) drive(4'b1010, 1'b1, 1'b0, 1'b1);
    // backpressure then release with no bubble
    drive(4'hF, 1'b1, 1'b0, 1'b1);
    repeat (3) drive(4'hF, 1'b0, 1'b0, 1'b1);
    repeat (2) drive(4'hF, 1'b1, 1'b0, 1'b1);
    // wrap/skip: grant 2 then requests on 0 and 1 only
    drive(4'h0, 1'b1, 1'b1, 1'b1);
    drive(4'b0100, 1'b1, 1'b0, 1'b1);
    drive(4'b0011, 1'b1, 1'b0, 1'b1);
    drive(4'b0011, 1'b1, 1'b0, 1'b1);
    // reset while a stalled word is held
    drive(4'hF, 1'b0, 1'b0, 1'b1);
    drive(4'hF, 1'b0, 1'b1, 1'b1);
    drive(4'h0, 1'b1, 1'b0, 1'b1);
    drive(4'h0, 1'b1, 1'b0, 1'b1);
    // random traffic with occasional reset
    repeat (400)
      drive(4'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0, 1'b0);
    // drain and confirm nothing is still owed
    repeat (3) drive(4'h0, 1'b1, 1'b0, 1'b0);
    chk("rr_owed_words", q0.size(), 0);
    chk("fx_owed_words", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
